mesh_switch_allocator: RTL
==========================

MESH_SWITCH_ALLOCATOR -- requirements
Module: mesh_switch_allocator

Interface
REQ-001 Parameter N_PORTS, default 5, number of crossbar ports; port 0 is local (c), then n,e,s,w.
REQ-002 Parameter CREDIT_DEPTH, default 4, downstream input buffer depth in flits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 i_output_req  input  [N_PORTS][N_PORTS]  per input, one-hot requested output; all-zero means idle.
REQ-006 i_tail  input  [N_PORTS]  per input, the head-of-queue flit is a packet tail (single-flit packet: tail=1).
REQ-007 i_credit  input  [N_PORTS]  per output, downstream freed one buffer slot this cycle.
REQ-008 o_sel  output  [N_PORTS][$clog2(N_PORTS)]  per output, unsigned index of the input driving it.
REQ-009 o_en  output  [N_PORTS]  per input, flit is read from the local input unit this cycle.
REQ-010 o_val  output  [N_PORTS]  per output, flit valid to downstream this cycle.
REQ-011 o_credit_err  output  1  sticky flag: credit returned to a full counter.

Function
REQ-012 Per output, credit counter width $clog2(CREDIT_DEPTH+1); no flit sent when counter is 0.
REQ-013 Counter: -1 on o_val, +1 on i_credit, unchanged when both occur in the same cycle.
REQ-014 i_credit with counter at CREDIT_DEPTH and no o_val: counter holds, o_credit_err set until reset.
REQ-015 Per output, FSM states IDLE and LOCKED; owner register holds locked input index.
REQ-016 IDLE: eligible requesters = inputs requesting this output; grant by round-robin starting at pointer.
REQ-017 IDLE grant with credit>0 and i_tail=0: o_val=1, go LOCKED with owner=winner next cycle.
REQ-018 IDLE grant with i_tail=1: o_val=1, stay IDLE, pointer = winner+1 mod N_PORTS.
REQ-019 LOCKED: only owner may be granted; other requesters ignored regardless of priority.
REQ-020 LOCKED, owner requesting, credit>0: o_val=1; if i_tail=1 go IDLE, pointer = owner+1 mod N_PORTS.
REQ-021 LOCKED, owner not requesting or credit=0: o_val=0, remain LOCKED (wormhole stall).
REQ-022 Pointer unchanged on non-tail grants and on cycles with no grant.
REQ-023 Grant decision is combinational from current state and inputs: zero-cycle latency request->o_en/o_val.
REQ-024 o_en[i] = OR over outputs of grant to input i; at most one output grants any input.
REQ-025 o_sel[j] = granted input index; 0 when o_val[j]=0 (never X/Z).
REQ-026 Input requesting a non-one-hot vector: treated as idle, no grant.

Reset
REQ-027 On reset_n low, immediately: counters = CREDIT_DEPTH, FSMs IDLE, owners 0, pointers 0, o_credit_err 0.
REQ-028 Outputs during reset: o_val, o_en all 0, o_sel all 0.
REQ-029 Reset mid-packet drops lock; first cycle after release arbitrates as fresh IDLE.

Structure
REQ-030 Package mesh_pkg holds alloc_state_t enum (IDLE, LOCKED) and N_PORTS/CREDIT_DEPTH defaults.
REQ-031 One sub-module mesh_rr_lock_arbiter (per output: round-robin, lock, pointer), instantiated N_PORTS times via generate.
REQ-032 Credit counters and error flag live in top level.

Verification
REQ-033 Inputs 1,2,3 request output 2 with single-flit packets, 3 cycles -> grants 1,2,3 in order, o_sel[2]=1,2,3.
REQ-034 Input 4 sends 3-flit packet to output 0, input 1 requests output 0 meanwhile -> input 1 granted only after tail, cycle 4.
REQ-035 Input 0 streams 6 single flits to output 3, no credits -> 4 o_val pulses then stall; one i_credit -> one more flit.
REQ-036 Same cycle o_val[1] and i_credit[1] with counter 2 -> counter stays 2.
REQ-037 i_credit[4] with counter 4, no traffic -> o_credit_err=1 next cycle, held until reset.
REQ-038 reset_n low while output 2 LOCKED mid-packet -> o_val=0 at once; after release new requester granted from pointer 0.

Source files
------------

// File: rtl/mesh_switch_allocator_pkg.sv
// Shared types and default sizing for the mesh switch allocator.
// Each crossbar output owns one allocation FSM of type alloc_state_t.
package mesh_pkg;

    localparam int N_PORTS_DEF      = 5;
    localparam int CREDIT_DEPTH_DEF = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

endpackage

// File: rtl/mesh_switch_allocator_arbiter.sv
// Per-output round-robin arbiter with wormhole lock.
// A multi-flit packet holds the output until its tail has been sent.
module mesh_rr_lock_arbiter
    import mesh_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int SW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_PORTS-1:0] i_req,
    input  logic [N_PORTS-1:0] i_tail,
    input  logic               i_credit_ok,
    output logic [N_PORTS-1:0] o_gnt,
    output logic               o_val,
    output logic [SW-1:0]      o_sel
);

    alloc_state_t r_state;
    logic [SW-1:0] r_owner;
    logic [SW-1:0] r_ptr;

    logic          w_found;
    logic          w_fire;
    logic [SW-1:0] w_winner;
    logic [SW-1:0] w_idx;
    logic [SW-1:0] w_ptr_next;

    // Search from the pointer upward with wrap; a lock bypasses the search.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = r_ptr;
        if (r_state == IDLE) begin
            for (int k = 0; k < N_PORTS; k++) begin
                if (!w_found && i_req[w_idx]) begin
                    w_found  = 1'b1;
                    w_winner = w_idx;
                end
                w_idx = (w_idx == SW'(N_PORTS - 1)) ? '0 : w_idx + 1'b1;
            end
        end else if (i_req[r_owner]) begin
            w_found  = 1'b1;
            w_winner = r_owner;
        end
    end

    assign w_fire     = w_found & i_credit_ok & reset_n;
    assign w_ptr_next = (w_winner == SW'(N_PORTS - 1)) ? '0 : w_winner + 1'b1;

    assign o_val = w_fire;
    assign o_sel = w_fire ? w_winner : '0;
    assign o_gnt = w_fire ? ({{(N_PORTS-1){1'b0}}, 1'b1} << w_winner) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else if (w_fire) begin
            if (i_tail[w_winner]) begin
                r_state <= IDLE;
                r_ptr   <= w_ptr_next;
            end else begin
                r_state <= LOCKED;
                r_owner <= w_winner;
            end
        end
    end

endmodule

// File: rtl/mesh_switch_allocator.sv
// Mesh router switch allocator: one lockable round-robin arbiter per output,
// gated by per-output downstream credit counters.
module mesh_switch_allocator
    import mesh_pkg::*;
#(
    parameter int  N_PORTS      = N_PORTS_DEF,
    parameter int  CREDIT_DEPTH = CREDIT_DEPTH_DEF,
    localparam int SW           = (N_PORTS > 1) ? $clog2(N_PORTS) : 1,
    localparam int CW           = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [N_PORTS-1:0][N_PORTS-1:0]   i_output_req,
    input  logic [N_PORTS-1:0]                i_tail,
    input  logic [N_PORTS-1:0]                i_credit,
    output logic [N_PORTS-1:0][SW-1:0]        o_sel,
    output logic [N_PORTS-1:0]                o_en,
    output logic [N_PORTS-1:0]                o_val,
    output logic                              o_credit_err
);

    logic [N_PORTS-1:0]              w_req_valid;
    logic [N_PORTS-1:0][N_PORTS-1:0] w_req_col;
    logic [N_PORTS-1:0][N_PORTS-1:0] w_gnt;
    logic [N_PORTS-1:0]              w_credit_ok;
    logic [N_PORTS-1:0]              w_err_hit;
    logic [CW-1:0]                   r_credit [N_PORTS];
    logic                            r_credit_err;

    // A malformed (non-one-hot) request vector is treated as idle.
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_in
        assign w_req_valid[gi] = $onehot(i_output_req[gi]);
    end

    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_out
        for (genvar gj = 0; gj < N_PORTS; gj++) begin : g_col
            assign w_req_col[gi][gj] = w_req_valid[gj] & i_output_req[gj][gi];
        end

        mesh_rr_lock_arbiter #(
            .N_PORTS (N_PORTS),
            .SW      (SW)
        ) u_arb (
            .clk         (clk),
            .reset_n     (reset_n),
            .i_req       (w_req_col[gi]),
            .i_tail      (i_tail),
            .i_credit_ok (w_credit_ok[gi]),
            .o_gnt       (w_gnt[gi]),
            .o_val       (o_val[gi]),
            .o_sel       (o_sel[gi])
        );

        assign w_credit_ok[gi] = (r_credit[gi] != '0);
        assign w_err_hit[gi]   = i_credit[gi] & ~o_val[gi] &
                                 (r_credit[gi] == CW'(CREDIT_DEPTH));

        // Send and return in the same cycle cancel out.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_credit[gi] <= CW'(CREDIT_DEPTH);
            end else if (o_val[gi] && !i_credit[gi]) begin
                r_credit[gi] <= r_credit[gi] - 1'b1;
            end else if (i_credit[gi] && !o_val[gi] && !w_err_hit[gi]) begin
                r_credit[gi] <= r_credit[gi] + 1'b1;
            end
        end
    end

    // Inputs request exactly one output, so at most one grant lands per input.
    always_comb begin
        o_en = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            o_en = o_en | w_gnt[j];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_credit_err <= 1'b0;
        end else if (|w_err_hit) begin
            r_credit_err <= 1'b1;
        end
    end

    assign o_credit_err = r_credit_err;

endmodule
